// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous write, registered read data.
// clr forces the read register to zero (used for erroneous responses).
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q, rdata_d;

    // Array write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Next read-register value: hold unless a read or clear is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (clr) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem[idx];
        end
    end

    // Read-data register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with wait states and ready handshake.
// Optional error checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] datain,
    input  logic              read,
    input  logic              write,
    output logic [WORD_W-1:0] dataout,
    output logic              ready,
    output logic              err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES != 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    op_e               op_q, op_d;
    logic              flag_q, flag_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic              new_err;
    op_e               new_op;
    logic [IDX_W-1:0]  new_idx;

    logic              commit;
    logic [IDX_W-1:0]  com_idx;
    logic [WORD_W-1:0] com_wdata;
    op_e               com_op;
    logic              com_err;
    logic              ram_we, ram_re, ram_clr;

    assign new_idx = addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
    // Simultaneous read+write resolves to a write.
    assign new_op  = write ? OP_WRITE : OP_READ;

`ifdef DMEM_ERR_CHECK_EN
    assign new_err = (addr[BYTE_OFF_W-1:0] != '0)
                   | ((addr >> (IDX_W + BYTE_OFF_W)) != '0)
                   | (read & write);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;
    assign new_err = 1'b0;
`endif

    // Next-state, capture, and commit decode; commit marks the edge entering RESP.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        op_d      = op_q;
        flag_d    = flag_q;
        commit    = 1'b0;
        com_idx   = idx_q;
        com_wdata = wdata_q;
        com_op    = op_q;
        com_err   = flag_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (read | write) begin
                    idx_d   = new_idx;
                    wdata_d = datain;
                    op_d    = new_op;
                    flag_d  = new_err;
                    if (WAIT_CYCLES != 0) begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end else begin
                        // Zero wait states: commit straight from the live inputs.
                        state_d   = RESP;
                        commit    = 1'b1;
                        com_idx   = new_idx;
                        com_wdata = datain;
                        com_op    = new_op;
                        com_err   = new_err;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = commit;
        err_d   = commit & com_err;
        // Reset on the commit edge discards the pending access.
        ram_we  = res & commit & ~com_err & (com_op == OP_WRITE);
        ram_re  = res & commit & ~com_err & (com_op == OP_READ);
        ram_clr = res & commit & com_err;
    end

    // State, counter, capture and output registers.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_q    <= OP_READ;
            flag_q  <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            flag_q  <= flag_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (res),
        .we    (ram_we),
        .re    (ram_re),
        .clr   (ram_clr),
        .idx   (com_idx),
        .wdata (com_wdata),
        .rdata (dataout)
    );

    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that services load/store requests from the CPU data port (`addr`, `datain`, `read`, `write`) and returns data with an explicit `ready` handshake. It replaces the zero-wait data memory on the board when variable memory latency must be exercised. It holds a word-addressed RAM, inserts a configurable number of wait states, and flags illegal accesses.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, default 2: wait states between acceptance and response; 0..15.
- `clk`  in  1  clock; all logic on rising edge.
- `res`  in  1  reset, synchronous, active-low.
- `addr`  in  32  byte address of the request.
- `datain`  in  32  store data.
- `read`  in  1  load request.
- `write`  in  1  store request.
- `dataout`  out  32  load data, valid while `ready`=1 on a read.
- `ready`  out  1  one-cycle response strobe.
- `err`  out  1  illegal access, valid while `ready`=1.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if `read|write`=1 at the edge, capture `addr`, `datain`, op, and an error flag. Go to BUSY if `WAIT_CYCLES`>0, else RESP. Inputs are ignored outside IDLE.
- BUSY: a 4-bit counter loads `WAIT_CYCLES-1` on entry and decrements each cycle. Go to RESP on the edge where the counter is 0.
- On the edge entering RESP:
  - Write (no error): store the word in RAM.
  - Read (no error): register the RAM word into `dataout`.
- RESP: `ready`=1 for exactly one cycle, `err` equals the captured flag, then return to IDLE.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`.
- Error conditions:
  - `addr[1:0]`≠0 (misaligned);
  - any `addr` bit above the index is set (out of range);
  - `read` and `write` both 1.
- On error: no RAM write, `dataout` is driven 0 during RESP, `err`=1.
- `dataout` holds its last read value between responses. A write response leaves it unchanged.
- Back-to-back: the requester updates `read`/`write` on the edge where it samples `ready`. A request present in the following IDLE cycle is accepted immediately, so there are no dead cycles beyond the protocol.
- Reset (`res`=0 at an edge):
  - State goes to IDLE; `ready`=0, `err`=0, `dataout`=0; the counter is cleared.
  - Any captured, uncommitted write is discarded.
  - RAM contents are not initialised and are unchanged by reset.

## Timing
- Request accepted at the end of IDLE cycle T → `ready` high in cycle T+1+`WAIT_CYCLES`.
- Default latency is 3 cycles from request to `ready`.
- Throughput is one access per `WAIT_CYCLES`+2 cycles.
- Store data is visible to a read accepted in any cycle after the store's RESP cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `DMEM_ERR_CHECK_EN`.
- Defined: error checks as described above; `err` is driven.
- Undefined:
  - `err` is tied 0.
  - `addr[1:0]` is ignored and addresses wrap modulo `DEPTH_WORDS`.
  - Simultaneous `read`+`write` is treated as a write, and `dataout` is unchanged.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE/BUSY/RESP);
  - op encoding (OP_READ/OP_WRITE);
  - `WORD_W`=32, byte-offset width 2.
- Sub-module `dmem_ram`: single-port, synchronous-write, synchronous-read array of `DEPTH_WORDS`×32.
- FSM, counter, capture registers and error logic live in the top level.

## Test plan
- Reset: drive `res`=0 for 2 cycles mid-run → `ready`=0, `err`=0, `dataout`=0 on the following cycle.
- Store then load: write 0xDEADBEEF @0x10 in cycle T → `ready` at T+3, `err`=0. Then read @0x10 → `ready` 3 cycles after acceptance with `dataout`=0xDEADBEEF.
- Back-to-back: preload 0x11111111 @0x0 and 0x22222222 @0x4. Issue both reads with the second presented in the cycle after the first `ready` → two responses 4 cycles apart with the correct data.
- Errors (macro defined):
  - write @0x13 → `err`=1 with `ready`, and word @0x10 unchanged;
  - read @0x400 (DEPTH 256) → `err`=1, `dataout`=0;
  - `read`+`write` both 1 → `err`=1, no write.
- Reset mid-access: write 0xCAFEF00D @0x20 (prior value 0x0), assert `res` during BUSY → `ready` never asserts, and a later read @0x20 returns 0x0.
- `WAIT_CYCLES`=0 build: read accepted in cycle T → `ready` in T+1; sustained reads achieve one response every 2 cycles.
